wshb_arbiter2: RTL

Two-master, one-slave Wishbone arbiter in the pixel_clk domain. It shares the single SDRAM Wishbone port between the VGA framebuffer reader (master 0) and the pattern/mire writer (master 1). Grants are round-robin and held for a whole bus cycle (cyc). A per-grant watchdog flags transactions that the slave never acknowledges.

---
 rtl/wshb_arbiter2_if.sv | 46 ++++
 rtl/wshb_arbiter2.sv | 127 ++++++++++++
 2 files changed

// File: rtl/wshb_arbiter2_if.sv
`default_nettype none
// ============================================================================
// Module  : wshb_arbiter2_if
// Brief   : Bus bundle for the two-master / one-slave Wishbone arbiter.
// Revision: 1.0
// ============================================================================
interface wshb_arbiter2_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [1:0]          m_cyc;
    logic [1:0]          m_stb;
    logic [1:0]          m_we;
    logic [2*AW-1:0]     m_adr;
    logic [2*DW-1:0]     m_dat_ms;
    logic [2*DW/8-1:0]   m_sel;
    logic [1:0]          m_ack;
    logic [1:0]          m_err;
    logic [DW-1:0]       m_dat_sm;

    logic                s_cyc;
    logic                s_stb;
    logic                s_we;
    logic [AW-1:0]       s_adr;
    logic [DW-1:0]       s_dat_ms;
    logic [DW/8-1:0]     s_sel;
    logic                s_ack;
    logic [DW-1:0]       s_dat_sm;

    // master: the arbiter, which owns the downstream slave port
    modport master (
        input  m_cyc, m_stb, m_we, m_adr, m_dat_ms, m_sel,
        output m_ack, m_err, m_dat_sm,
        output s_cyc, s_stb, s_we, s_adr, s_dat_ms, s_sel,
        input  s_ack, s_dat_sm
    );

    // slave: the surrounding masters and SDRAM port seen from outside
    modport slave (
        output m_cyc, m_stb, m_we, m_adr, m_dat_ms, m_sel,
        input  m_ack, m_err, m_dat_sm,
        input  s_cyc, s_stb, s_we, s_adr, s_dat_ms, s_sel,
        output s_ack, s_dat_sm
    );
endinterface
`default_nettype wire

// File: rtl/wshb_arbiter2.sv
`default_nettype none
// ============================================================================
// Module  : wshb_arbiter2
// Brief   : Round-robin two-master Wishbone arbiter with per-grant watchdog.
// Revision: 1.0
// ============================================================================
module wshb_arbiter2 #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  wire logic          pixel_clk,
    input  wire logic          pixel_rst,
    wshb_arbiter2_if.master    bus,
    output logic [1:0]         gnt
);
    localparam int SW = DW / 8;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GNT0 = 2'd1,
        S_GNT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // A tie in IDLE goes to the master that was not granted last
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (bus.m_cyc[0] && (!bus.m_cyc[1] || last_q))
                    state_d = S_GNT0;
                else if (bus.m_cyc[1])
                    state_d = S_GNT1;
            end
            S_GNT0: begin
                if (!bus.m_cyc[0])
                    state_d = bus.m_cyc[1] ? S_GNT1 : S_IDLE;
            end
            S_GNT1: begin
                if (!bus.m_cyc[1])
                    state_d = bus.m_cyc[0] ? S_GNT0 : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_GNT0 && state_q != S_GNT0)
            last_d = 1'b0;
        else if (state_d == S_GNT1 && state_q != S_GNT1)
            last_d = 1'b1;
    end

    assign gnt = {state_q == S_GNT1, state_q == S_GNT0};

    always_comb begin
        bus.s_cyc    = 1'b0;
        bus.s_stb    = 1'b0;
        bus.s_we     = 1'b0;
        bus.s_adr    = '0;
        bus.s_dat_ms = '0;
        bus.s_sel    = '0;
        case (state_q)
            S_GNT0: begin
                bus.s_cyc    = bus.m_cyc[0];
                bus.s_stb    = bus.m_stb[0];
                bus.s_we     = bus.m_we[0];
                bus.s_adr    = bus.m_adr[0 +: AW];
                bus.s_dat_ms = bus.m_dat_ms[0 +: DW];
                bus.s_sel    = bus.m_sel[0 +: SW];
            end
            S_GNT1: begin
                bus.s_cyc    = bus.m_cyc[1];
                bus.s_stb    = bus.m_stb[1];
                bus.s_we     = bus.m_we[1];
                bus.s_adr    = bus.m_adr[AW +: AW];
                bus.s_dat_ms = bus.m_dat_ms[DW +: DW];
                bus.s_sel    = bus.m_sel[SW +: SW];
            end
            default: ;
        endcase
    end

    assign bus.m_ack    = {2{bus.s_ack}} & gnt & bus.m_stb;
    assign bus.m_dat_sm = bus.s_dat_sm;

    generate
        if (TIMEOUT > 0) begin : g_wdog
            logic [CW-1:0] cnt_q, cnt_d;
            logic          expire;

            // An ack in the expiring cycle suppresses the error
            always_comb begin
                expire = (state_q != S_IDLE) && bus.s_stb && !bus.s_ack &&
                         (cnt_q == CW'(TIMEOUT - 1));
                cnt_d  = '0;
                if ((state_q != S_IDLE) && (state_d == state_q) &&
                    bus.s_stb && !bus.s_ack && !expire)
                    cnt_d = cnt_q + 1'b1;
            end

            always_ff @(posedge pixel_clk or posedge pixel_rst) begin
                if (pixel_rst)
                    cnt_q <= '0;
                else
                    cnt_q <= cnt_d;
            end

            assign bus.m_err = expire ? gnt : 2'b00;
        end else begin : g_nowdog
            assign bus.m_err = 2'b00;
        end
    endgenerate
endmodule
`default_nettype wire
